// File: rtl/text_pkg.sv
// Shared types and helpers for the text pixel blender: the colour type,
// symbolic text-area alpha codes and the alpha-code to weight mapping.
package text_pkg;

  typedef logic [11:0] color_t;

  // Text-area alpha codes; the weight is expressed in eighths.
  localparam logic [2:0] ALPHA_0     = 3'd0;  // 0/8
  localparam logic [2:0] ALPHA_12    = 3'd1;  // 1/8
  localparam logic [2:0] ALPHA_25    = 3'd2;  // 2/8
  localparam logic [2:0] ALPHA_50    = 3'd3;  // 4/8
  localparam logic [2:0] ALPHA_75    = 3'd4;  // 6/8
  localparam logic [2:0] ALPHA_88    = 3'd5;  // 7/8
  localparam logic [2:0] ALPHA_100   = 3'd6;  // 8/8
  localparam logic [2:0] ALPHA_100_B = 3'd7;  // alias of fully opaque

  // Map a 3-bit alpha code to a blend weight in eighths (0..8).
  function automatic logic [3:0] alpha_weight(input logic [2:0] code);
    logic [3:0] w;
    case (code)
      ALPHA_0:  w = 4'd0;
      ALPHA_12: w = 4'd1;
      ALPHA_25: w = 4'd2;
      ALPHA_50: w = 4'd4;
      ALPHA_75: w = 4'd6;
      ALPHA_88: w = 4'd7;
      default:  w = 4'd8;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/text_pixel_blender8x8_font_rom.sv
// Synchronous 2048 x 8 font ROM, address {char[7:0], row[2:0]}.
// The read is registered so the array maps onto block RAM.
module font_rom8x8 #(
  parameter FONT_FILE = "../font/font8x8.bits"
) (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [7:0] rom_mem [0:2047];

  initial begin
    for (int a = 0; a < 2048; a++) rom_mem[a] = 8'h00;
  end

  // Registered read: glyph byte valid one clock after the address.
  always_ff @(posedge clk) begin
    data <= rom_mem[addr];
  end

endmodule

// File: rtl/text_pixel_blender8x8.sv
// Per-pixel text renderer: font lookup, fg/bg select, then alpha blend over
// the layer beneath. Two-stage pipeline, one pixel per clock.
// Optional macro TEXT_PIXEL_BLANK_EN adds i_blank, which forces the pixel
// it travels with to black.
import text_pkg::*;

module text_pixel_blender8x8 #(
  parameter     FONT_FILE = "../font/font8x8.bits",
  parameter int COLOR_W   = 12
) (
  input  logic               i_pix_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_char,
  input  logic [2:0]         i_row,
  input  logic [2:0]         i_column,
  input  logic [COLOR_W-1:0] i_fg_color,
  input  logic [COLOR_W-1:0] i_bg_color,
  input  logic [COLOR_W-1:0] i_under_color,
  input  logic [2:0]         i_alpha,
`ifdef TEXT_PIXEL_BLANK_EN
  input  logic               i_blank,
`endif
  output logic [COLOR_W-1:0] o_color
);

  localparam int CH_W  = COLOR_W / 3;
  localparam int MIX_W = CH_W + 3;   // channel * weight(<=8) never exceeds this

  logic [7:0]         glyph_byte;
  logic [2:0]         column_reg;
  logic [COLOR_W-1:0] fg_reg;
  logic [COLOR_W-1:0] bg_reg;
  logic [COLOR_W-1:0] under_reg;
  logic [2:0]         alpha_reg;
  logic               glyph_bit;
  logic [COLOR_W-1:0] inter_color;
  logic [3:0]         weight;
  logic [3:0]         inv_weight;
  logic [COLOR_W-1:0] blend_next;

  font_rom8x8 #(
    .FONT_FILE(FONT_FILE)
  ) u_font_rom (
    .clk  (i_pix_clk),
    .addr ({i_char, i_row}),
    .data (glyph_byte)
  );

  // Stage 1: delay the per-pixel attributes alongside the ROM read.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      column_reg <= '0;
      fg_reg     <= '0;
      bg_reg     <= '0;
      under_reg  <= '0;
      alpha_reg  <= '0;
    end else begin
      column_reg <= i_column;
      fg_reg     <= i_fg_color;
      bg_reg     <= i_bg_color;
      under_reg  <= i_under_color;
      alpha_reg  <= i_alpha;
    end
  end

  // Pick the glyph bit (column 0 is the MSB) and the colour it selects.
  always_comb begin
    glyph_bit   = glyph_byte[3'd7 - column_reg];
    inter_color = glyph_bit ? fg_reg : bg_reg;
    weight      = alpha_weight(alpha_reg);
    inv_weight  = 4'd8 - weight;
  end

  // Per-channel truncating blend: (inter*w + under*(8-w)) >> 3.
  for (genvar gi = 0; gi < 3; gi++) begin : g_channel
    logic [MIX_W-1:0] mix;
    assign mix = ({3'b000, inter_color[gi*CH_W +: CH_W]} * {{(MIX_W-4){1'b0}}, weight})
               + ({3'b000, under_color_ch(gi)} * {{(MIX_W-4){1'b0}}, inv_weight});
    assign blend_next[gi*CH_W +: CH_W] = mix[MIX_W-1:3];
  end

  function automatic logic [CH_W-1:0] under_color_ch(input int ch);
    return under_reg[ch*CH_W +: CH_W];
  endfunction

`ifdef TEXT_PIXEL_BLANK_EN
  logic blank_reg;

  // Blank flag travels with its pixel through stage 1.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      blank_reg <= 1'b0;
    end else begin
      blank_reg <= i_blank;
    end
  end

  // Stage 2: register the blended colour, black when the pixel is blanked.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_color <= '0;
    end else begin
      o_color <= blank_reg ? '0 : blend_next;
    end
  end
`else
  // Stage 2: register the blended colour.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_color <= '0;
    end else begin
      o_color <= blend_next;
    end
  end
`endif

endmodule

// File: tb/tb_text_pixel_blender8x8.sv
// Directed bench for text_pixel_blender8x8. Loads a small test font into the
// ROM, then steps hand-computed pixels through the 2-clock pipeline.
module tb_text_pixel_blender8x8;

  logic        i_pix_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_char;
  logic [2:0]  i_row;
  logic [2:0]  i_column;
  logic [11:0] i_fg_color;
  logic [11:0] i_bg_color;
  logic [11:0] i_under_color;
  logic [2:0]  i_alpha;
  logic        i_blank;
  logic [11:0] o_color;

  int total = 0;
  int bad   = 0;

  // Expected-value pipeline mirroring the 2-clock latency.
  logic [11:0] in_exp, s1_exp, o_exp;
  string       in_tag, s1_tag, o_tag;

  always #5 i_pix_clk = ~i_pix_clk;

  text_pixel_blender8x8 dut (
    .i_pix_clk     (i_pix_clk),
    .i_rst         (i_rst),
    .i_char        (i_char),
    .i_row         (i_row),
    .i_column      (i_column),
    .i_fg_color    (i_fg_color),
    .i_bg_color    (i_bg_color),
    .i_under_color (i_under_color),
    .i_alpha       (i_alpha),
`ifdef TEXT_PIXEL_BLANK_EN
    .i_blank       (i_blank),
`endif
    .o_color       (o_color)
  );

  task automatic apply(input logic rst, input logic [7:0] ch, input logic [2:0] row,
                       input logic [2:0] col, input logic [11:0] fg, input logic [11:0] bg,
                       input logic [11:0] under, input logic [2:0] a, input logic blank,
                       input logic [11:0] exp, input string t);
    i_rst         = rst;
    i_char        = ch;
    i_row         = row;
    i_column      = col;
    i_fg_color    = fg;
    i_bg_color    = bg;
    i_under_color = under;
    i_alpha       = a;
    i_blank       = blank;
    in_exp        = exp;
    in_tag        = t;
  endtask

  // One clock: advance the expectation pipeline and check o_color.
  task automatic tick();
    @(posedge i_pix_clk);
    #1;
    if (i_rst) begin
      o_exp  = 12'h000;
      o_tag  = {in_tag, "_rst"};
      s1_exp = 12'h000;
      s1_tag = {in_tag, "_rst1"};
    end else begin
      o_exp  = s1_exp;
      o_tag  = s1_tag;
      s1_exp = in_exp;
      s1_tag = in_tag;
    end
    total++;
    assert (o_color === o_exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", o_tag, o_color, o_exp);
    end
    $display("pixel %s o_color=%h expected=%h", o_tag, o_color, o_exp);
  endtask

  initial begin
    apply(1'b1, 8'h00, 3'd0, 3'd0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0, 12'h000, "reset");
    s1_exp = 12'h000;
    s1_tag = "init";
    // Test font: everything blank, 0xDB solid, 0x41 row 3 = 8'h80.
    #1;
    for (int a = 0; a < 2048; a++) dut.u_font_rom.rom_mem[a] = 8'h00;
    for (int r = 0; r < 8; r++) dut.u_font_rom.rom_mem[{8'hDB, r[2:0]}] = 8'hFF;
    dut.u_font_rom.rom_mem[{8'h41, 3'd3}] = 8'h80;

    // Reset state.
    tick();
    tick();

    // Solid glyph selects fg.
    apply(1'b0, 8'hDB, 3'd2, 3'd5, 12'hF00, 12'h00F, 12'h0AB, 3'd6, 1'b0, 12'hF00, "solid");
    tick();
    // Empty glyph selects bg; alpha 0 shows the layer beneath.
    apply(1'b0, 8'h20, 3'd4, 3'd3, 12'hF00, 12'h0F0, 12'h123, 3'd6, 1'b0, 12'h0F0, "empty_a6");
    tick();
    apply(1'b0, 8'h20, 3'd4, 3'd3, 12'hF00, 12'h0F0, 12'h123, 3'd0, 1'b0, 12'h123, "empty_a0");
    tick();

    // Bit order sweep: only column 0 is set in row byte 8'h80.
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, 8'h41, 3'd3, c[2:0], 12'hABC, 12'h321, 12'h000, 3'd6, 1'b0,
            (c == 0) ? 12'hABC : 12'h321, $sformatf("col%0d", c));
      tick();
    end

    // Blend arithmetic.
    apply(1'b0, 8'hDB, 3'd0, 3'd0, 12'hFFF, 12'h000, 12'h000, 3'd3, 1'b0, 12'h777, "blend_a3");
    tick();
    apply(1'b0, 8'hDB, 3'd1, 3'd1, 12'hFFF, 12'h000, 12'h000, 3'd1, 1'b0, 12'h111, "blend_a1");
    tick();
    apply(1'b0, 8'hDB, 3'd2, 3'd2, 12'hFFF, 12'h000, 12'h000, 3'd5, 1'b0, 12'hDDD, "blend_a5");
    tick();
    apply(1'b0, 8'hDB, 3'd3, 3'd3, 12'hFFF, 12'h000, 12'h000, 3'd7, 1'b0, 12'hFFF, "blend_a7");
    tick();
    apply(1'b0, 8'hDB, 3'd4, 3'd4, 12'hFFF, 12'h000, 12'h000, 3'd2, 1'b0, 12'h333, "blend_a2");
    tick();
    apply(1'b0, 8'hDB, 3'd5, 3'd5, 12'h000, 12'hFFF, 12'hFFF, 3'd4, 1'b0, 12'h333, "blend_a4_inv");
    tick();
    apply(1'b0, 8'hDB, 3'd6, 3'd6, 12'h8F0, 12'h000, 12'h0F8, 3'd3, 1'b0, 12'h4F4, "blend_mix");
    tick();
    apply(1'b0, 8'h20, 3'd7, 3'd7, 12'hFFF, 12'h000, 12'h9C6, 3'd6, 1'b0, 12'h000, "bg_black");
    tick();

    // Reset mid-stream: the pixel applied during reset is dropped.
    apply(1'b0, 8'hDB, 3'd0, 3'd0, 12'hEEE, 12'h000, 12'h000, 3'd6, 1'b0, 12'hEEE, "pre_rst");
    tick();
    apply(1'b1, 8'hDB, 3'd0, 3'd0, 12'hFFF, 12'h000, 12'h000, 3'd6, 1'b0, 12'hFFF, "mid_rst");
    tick();
    apply(1'b0, 8'hDB, 3'd1, 3'd4, 12'h5A5, 12'h000, 12'h000, 3'd6, 1'b0, 12'h5A5, "post_rst");
    tick();
    apply(1'b0, 8'hDB, 3'd1, 3'd4, 12'hFFF, 12'h000, 12'h000, 3'd6, 1'b0, 12'hFFF, "white0");
    tick();

`ifdef TEXT_PIXEL_BLANK_EN
    // Blank one pixel of a white stream.
    apply(1'b0, 8'hDB, 3'd2, 3'd0, 12'hFFF, 12'h000, 12'h000, 3'd6, 1'b1, 12'h000, "blanked");
    tick();
    apply(1'b0, 8'hDB, 3'd2, 3'd1, 12'hFFF, 12'h000, 12'h000, 3'd6, 1'b0, 12'hFFF, "white1");
    tick();
`else
    apply(1'b0, 8'hDB, 3'd2, 3'd0, 12'hFFF, 12'h000, 12'h000, 3'd6, 1'b1, 12'hFFF, "white_b");
    tick();
    apply(1'b0, 8'hDB, 3'd2, 3'd1, 12'hFFF, 12'h000, 12'h000, 3'd6, 1'b0, 12'hFFF, "white1");
    tick();
`endif

    // Flush the pipeline.
    apply(1'b0, 8'h20, 3'd0, 3'd0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0, 12'h000, "flush");
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
